// File: rtl/tt_sub4_pkg.sv
// Shared constants and state encoding for the bit-serial 4-bit subtractor tile.
package tt_sub4_pkg;

    localparam int SUB4_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub4_state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Single combinational full-adder cell, reused every clock by the serial subtractor.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_subtract4_serial.sv
// Bit-serial 4-bit subtractor: A - B computed LSB-first as A + ~B + 1, one bit per clock.
module tt_um_subtract4_serial
    import tt_sub4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    sub4_state_t         state_q, state_d;
    logic [1:0]          cnt_q;
    logic                carry_q;
    logic [SUB4_W-1:0]   a_sh_q, b_sh_q, res_sh_q;
    logic                a_msb_q, b_msb_q;
    logic [SUB4_W-1:0]   d_q;
    logic                borrow_q, ovf_q;
    logic                fa_s, fa_cout;
    logic                start, last_bit, latch, finish;
    logic                unused_uio;

    assign start    = uio_in[0];
    assign last_bit = (cnt_q == 2'(SUB4_W - 1));

    // Upper bidirectional pins carry no function in this tile.
    assign unused_uio = &{1'b0, uio_in[7:1]};

    serial_fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (~b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    latch   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            if (latch) begin
                a_sh_q  <= ui_in[3:0];
                b_sh_q  <= ui_in[7:4];
                a_msb_q <= ui_in[3];
                b_msb_q <= ui_in[7];
                carry_q <= 1'b1;
                cnt_q   <= '0;
            end else if (state_q == ST_SHIFT) begin
                a_sh_q   <= a_sh_q >> 1;
                b_sh_q   <= b_sh_q >> 1;
                res_sh_q <= {fa_s, res_sh_q[SUB4_W-1:1]};
                carry_q  <= fa_cout;
                cnt_q    <= cnt_q + 2'd1;
            end
            // Final bit: fa_s is D[3], so sign-based overflow is decided here.
            if (finish) begin
                d_q      <= {fa_s, res_sh_q[SUB4_W-1:1]};
                borrow_q <= ~fa_cout;
                ovf_q    <= (a_msb_q ^ b_msb_q) & (fa_s ^ a_msb_q);
            end
        end
    end

    assign uo_out  = {(state_q == ST_DONE), (state_q == ST_SHIFT), ovf_q, borrow_q, d_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_subtract4_serial.sv
// Directed-vector bench for the bit-serial 4-bit subtractor tile.
module tb_tt_um_subtract4_serial;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    tt_um_subtract4_serial dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for exactly one edge.
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
        ui_in  = {b, a};
        uio_in = 8'h01;
        tick();
        uio_in = 8'h00;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out got=%h want=00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio got=%h/%h want=00/00", uio_out, uio_oe);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset got=%h want=00", uo_out);
        end
    endtask

    task automatic test_arith(input string name, input logic [3:0] a, input logic [3:0] b,
                              input logic [7:0] want);
        pulse_start(a, b);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (uo_out[7:6] !== 2'b01) begin
                errors++;
                $display("FAIL %s_busy%0d got=%b want=01", name, i, uo_out[7:6]);
            end
            if (i < 3) tick();
        end
        tick();
        checks++;
        if (uo_out !== want) begin
            errors++;
            $display("FAIL %s_result got=%h want=%h", name, uo_out, want);
        end
        tick();
        checks++;
        if (uo_out !== want) begin
            errors++;
            $display("FAIL %s_hold got=%h want=%h", name, uo_out, want);
        end
    endtask

    // Previous result is 8-1 (fields 6'h27); operands/start noise and ena stalls mid-SHIFT.
    task automatic test_ignore_and_stall();
        pulse_start(4'h5, 4'h2);
        ui_in  = 8'hFF;
        uio_in = 8'h01;
        tick();
        checks++;
        if (uo_out !== 8'h67) begin
            errors++;
            $display("FAIL shift_holds_prev got=%h want=67", uo_out);
        end
        uio_in = 8'h00;
        ena    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            uio_in = (i == 1) ? 8'h01 : 8'h00;
            tick();
            checks++;
            if (uo_out !== 8'h67) begin
                errors++;
                $display("FAIL stall%0d got=%h want=67", i, uo_out);
            end
        end
        ena    = 1'b1;
        uio_in = 8'h00;
        tick();
        tick();
        checks++;
        if (uo_out !== 8'h67) begin
            errors++;
            $display("FAIL stall_not_early got=%h want=67", uo_out);
        end
        tick();
        checks++;
        if (uo_out !== 8'h83) begin
            errors++;
            $display("FAIL stall_result got=%h want=83", uo_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        ui_in  = {4'h1, 4'h6};
        uio_in = 8'h01;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 4 || k == 9) want = 8'h85;
            else if (k < 4)       want = 8'h43;
            else                  want = 8'h45;
            checks++;
            if (uo_out !== want) begin
                errors++;
                $display("FAIL b2b_edge%0d got=%h want=%h", k, uo_out, want);
            end
        end
        uio_in = 8'h00;
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (uo_out !== 8'h85) begin
            errors++;
            $display("FAIL b2b_final got=%h want=85", uo_out);
        end
    endtask

    task automatic test_reset_mid_shift();
        pulse_start(4'h7, 4'h3);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%h want=00", uo_out);
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_stays_idle got=%h want=00", uo_out);
        end
        pulse_start(4'h2, 4'h5);
        tick();
        tick();
        tick();
        checks++;
        if (uo_out !== 8'h40) begin
            errors++;
            $display("FAIL post_reset_busy got=%h want=40", uo_out);
        end
        tick();
        checks++;
        if (uo_out !== 8'h9D) begin
            errors++;
            $display("FAIL post_reset_result got=%h want=9d", uo_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith("a7b3", 4'h7, 4'h3, 8'h84);
        test_arith("a3b9", 4'h3, 4'h9, 8'hBA);
        test_arith("a0b0", 4'h0, 4'h0, 8'h80);
        test_arith("aFbF", 4'hF, 4'hF, 8'h80);
        test_arith("a8b1", 4'h8, 4'h1, 8'hA7);
        test_ignore_and_stall();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_subtract4_serial.md
# tt_um_subtract4_serial

Bit-serial 4-bit subtractor tile: latches two 4-bit operands from the dedicated inputs on a start request and computes A − B one bit per clock with a single full-adder cell (B inverted, carry-in 1). Difference, unsigned borrow and signed overflow are presented registered on the dedicated outputs. It is the subtract-direction companion of the team's combinational 4-bit adder tile and uses the same pin mapping for operands.

## Interface
- No parameters; width fixed at 4 (constant `SUB4_W` = 4).
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  clock enable; when 0 all registers hold
- ui_in  in  8  [3:0] operand A, [7:4] operand B (unsigned or two's complement)
- uio_in  in  8  [0] start (level-sampled); [7:1] unused
- uo_out  out  8  [3:0] difference D, [4] borrow, [5] signed overflow, [6] busy, [7] done
- uio_out  out  8  constant 0
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs)

## Operation
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: on edge with start=1 → latch A, B into shift registers, carry ← 1, bit counter ← 0, go to SHIFT.
- SHIFT: each edge processes bit `cnt`: s = a0 ^ ~b0 ^ c, c ← majority(a0, ~b0, c); s shifted into result register MSB-first-in (ends LSB-aligned); A, B shift right; cnt increments.
- After bit 3 is processed: D ← assembled result, borrow ← ~final carry, overflow ← (A[3] ≠ B[3]) & (D[3] ≠ A[3]) using latched operands; go to DONE.
- DONE: done=1; result held. start=1 → relatch operands and go to SHIFT (same as IDLE). start=0 → stay in DONE.
- start while in SHIFT: ignored; operands on ui_in ignored outside the latch edge.
- Output fields D/borrow/overflow update only on the completion edge; they keep the previous result throughout SHIFT.
- busy = (state == SHIFT); done = (state == DONE); both registered state decodes, never both 1.
- ena=0: state, counter, shift and output registers frozen; operation resumes where it stopped.

## Timing
- Reset (rst_n=0, async): state IDLE, uo_out = 8'h00, carry 0, counter 0, shift registers 0; uio_out = uio_oe = 0 always.
- Latency: start sampled at edge N → busy=1 after N; D/borrow/overflow valid and done=1 after edge N+4; busy falls at N+4.
- Throughput: with start held high, one result per 5 edges (DONE occupies one edge before relatch).
- Reset asserted mid-SHIFT: operation aborted, outputs return to 0 immediately; no partial result survives.
- Counter wrap: 2-bit counter reaching 3 triggers completion; no fifth shift cycle.
- Operands equal: D=0, borrow=0, overflow=0.

## Structure
- Shared package/include `tt_sub4_pkg`: `SUB4_W`, state encodings `ST_IDLE`=0, `ST_SHIFT`=1, `ST_DONE`=2.
- One sub-module `serial_fa_cell`: combinational full adder (a, b, cin → s, cout); top instantiates one with b driven by inverted B LSB.
- Top holds FSM, counter, carry flop, operand shift registers, result/flag registers.

## Test plan
- A=7, B=3, pulse start 1 cycle → busy for 4 edges, then D=4, borrow=0, overflow=0, done=1 held.
- A=3, B=9 → D=0xA, borrow=1, overflow=1.
- A=8, B=1 → D=7, borrow=0, overflow=1; A=0, B=0 → D=0, all flags 0.
- Start A=5,B=2; change ui_in to A=F,B=F and toggle start during SHIFT → result still D=3, no restart; ena=0 for 3 cycles mid-SHIFT stretches latency by exactly 3.
- start held high, A=6,B=1 → done pulses 1 cycle every 5 edges, D=5 each time.
- rst_n low at second SHIFT edge → uo_out=0x00 immediately, state IDLE; next start yields correct result after 4 further edges.
